// File: rtl/ram_arb2_pkg.sv
// rtl/ram_arb2_pkg.sv - shared types, port indices and helpers for the two-port RAM arbiter
package ram_arb2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int PORT_IF = 0;
    localparam int PORT_LS = 1;
    localparam int PERF_W  = 16;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == {PERF_W{1'b1}}) ? v : v + PERF_W'(1);
    endfunction

    function automatic logic [1:0] port_mask(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2
    import ram_arb2_pkg::*;
(
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic       pick,
    output logic       any_valid
);

    // Under contention the port that did not win last time goes next.
    always_comb begin
        any_valid = |req_valid;
        if (req_valid == 2'b11) begin
            pick = ~last_grant;
        end else begin
            pick = req_valid[PORT_LS];
        end
    end

endmodule

// File: rtl/ram_arb2_ctrl.sv
// rtl/ram_arb2_ctrl.sv - two-port round-robin sequencer for a single-port synchronous RAM
// Optional grant/contention counters are built when RAM_ARB2_PERF_EN is defined.
module ram_arb2_ctrl
    import ram_arb2_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr0,
    input  logic [ADDR_WIDTH-1:0] req_addr1,
    input  logic [DATA_WIDTH-1:0] req_wdata0,
    input  logic [DATA_WIDTH-1:0] req_wdata1,
    output logic [1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_we,
    output logic                  ram_oe,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic [PERF_W-1:0]     perf_grant0,
    output logic [PERF_W-1:0]     perf_grant1,
    output logic [PERF_W-1:0]     perf_conflict
);

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  pick;
    logic                  any_valid;
    logic                  handshake;

    rr_arb2 u_arb (
        .req_valid  (req_valid),
        .last_grant (last_grant_q),
        .pick       (pick),
        .any_valid  (any_valid)
    );

    assign handshake = |(req_valid & req_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (handshake) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The captured request doubles as the RAM pin drivers, so the pins hold between ops.
    always_comb begin
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        if (handshake) begin
            last_grant_d = pick;
            we_d         = req_we[pick];
            addr_d       = pick ? req_addr1 : req_addr0;
            wdata_d      = pick ? req_wdata1 : req_wdata0;
        end
    end

    always_comb begin
        req_ready   = 2'b00;
        rsp_valid   = 2'b00;
        rsp_rdata   = '0;
        ram_we      = 1'b0;
        ram_oe      = 1'b0;
        ram_address = addr_q;
        ram_data_in = wdata_q;
        case (state_q)
            IDLE: begin
                if (!reset && any_valid) req_ready = port_mask(pick);
            end
            ACCESS: begin
                ram_we = we_q;
                ram_oe = !we_q;
            end
            RESP: begin
                if (!reset) begin
                    rsp_valid = port_mask(last_grant_q);
                    if (!we_q) rsp_rdata = ram_data_out;
                end
            end
            default: ;
        endcase
    end

`ifdef RAM_ARB2_PERF_EN
    logic [PERF_W-1:0] perf_grant0_q, perf_grant0_d;
    logic [PERF_W-1:0] perf_grant1_q, perf_grant1_d;
    logic [PERF_W-1:0] perf_conflict_q, perf_conflict_d;

    always_comb begin
        perf_grant0_d   = perf_grant0_q;
        perf_grant1_d   = perf_grant1_q;
        perf_conflict_d = perf_conflict_q;
        if (handshake && !pick) perf_grant0_d = sat_inc(perf_grant0_q);
        if (handshake && pick)  perf_grant1_d = sat_inc(perf_grant1_q);
        if (state_q == IDLE && req_valid == 2'b11) perf_conflict_d = sat_inc(perf_conflict_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_grant0_q   <= '0;
            perf_grant1_q   <= '0;
            perf_conflict_q <= '0;
        end else begin
            perf_grant0_q   <= perf_grant0_d;
            perf_grant1_q   <= perf_grant1_d;
            perf_conflict_q <= perf_conflict_d;
        end
    end

    assign perf_grant0   = perf_grant0_q;
    assign perf_grant1   = perf_grant1_q;
    assign perf_conflict = perf_conflict_q;
`else
    assign perf_grant0   = '0;
    assign perf_grant1   = '0;
    assign perf_conflict = '0;
`endif

endmodule

// File: tb/tb_ram_arb2_ctrl.sv
// tb/tb_ram_arb2_ctrl.sv - self-checking bench for ram_arb2_ctrl with a behavioural RAM and request model
module tb_ram_arb2_ctrl;

    localparam logic [63:0] DB   = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] CAFE = 64'hCAFE_0000_1234_5678;
    localparam int          NRND = 400;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
    logic [9:0]  req_addr0, req_addr1, ram_address;
    logic [63:0] req_wdata0, req_wdata1, rsp_rdata, ram_data_in;
    logic        ram_we, ram_oe;
    logic [63:0] ram_data_out = '0;
    logic [15:0] perf_grant0, perf_grant1, perf_conflict;

    logic [63:0] ram_mem [0:1023] = '{default: '0};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_address] <= ram_data_in;
        if (ram_oe) ram_data_out <= ram_mem[ram_address];
    end

    ram_arb2_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_we(ram_we), .ram_oe(ram_oe), .ram_data_out(ram_data_out),
        .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_conflict(perf_conflict)
    );

    typedef struct {
        logic [1:0]  v, we;
        logic [9:0]  a0, a1;
        logic [63:0] d0, d1;
        logic [1:0]  e_rdy, e_rsp;
        logic [63:0] e_rdata;
        logic        e_we, e_oe;
        logic [9:0]  e_addr;
        logic [63:0] e_din;
    } vec_t;

    typedef struct {
        int          due;
        logic        port;
        logic [63:0] data;
    } rsp_t;

    int checks = 0;
    int errors = 0;

    vec_t        tbl [18];
    int          hs_cyc [$];
    logic        hs_port [$];
    int          oe_cnt, op_cnt, rsp0_cnt, rsp1_cnt;
    rsp_t        rq [$];
    rsp_t        r;
    logic [63:0] mmem [8];
    logic        cv [2], cwe [2], hold [2];
    logic [2:0]  ca [2];
    logic [63:0] cd [2];
    logic        last, win;
    logic [1:0]  exp_rdy;
    int          busy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = 2'b01; req_we = 2'b00;
        tick();
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_ram_oe", ram_oe, 1'b0);
        chk("rst_ram_address", ram_address, 10'h000);
        chk("rst_ram_data_in", ram_data_in, 64'h0);
        chk("rst_rsp_rdata", rsp_rdata, 64'h0);
        reset = 1'b0; req_valid = 2'b00;
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_we = '0;
        req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;

        //            v      we     a0      a1      d0  d1    rdy    rsp    rdata we   oe   addr    din
        tbl[0]  = '{2'b01, 2'b01, 10'h005, 10'h000, DB, 0,    2'b01, 2'b00, 0,    1'b0, 1'b0, 10'h000, 0};
        tbl[1]  = '{2'b00, 2'b00, 10'h000, 10'h000, 0,  0,    2'b00, 2'b00, 0,    1'b1, 1'b0, 10'h005, DB};
        tbl[2]  = '{2'b00, 2'b00, 10'h000, 10'h000, 0,  0,    2'b00, 2'b01, 0,    1'b0, 1'b0, 10'h005, 0};
        tbl[3]  = '{2'b01, 2'b00, 10'h005, 10'h000, 0,  0,    2'b01, 2'b00, 0,    1'b0, 1'b0, 10'h005, 0};
        tbl[4]  = '{2'b00, 2'b00, 10'h000, 10'h000, 0,  0,    2'b00, 2'b00, 0,    1'b0, 1'b1, 10'h005, 0};
        tbl[5]  = '{2'b00, 2'b00, 10'h000, 10'h000, 0,  0,    2'b00, 2'b01, DB,   1'b0, 1'b0, 10'h005, 0};
        tbl[6]  = '{2'b11, 2'b00, 10'h010, 10'h020, 0,  0,    2'b10, 2'b00, 0,    1'b0, 1'b0, 10'h005, 0};
        tbl[7]  = '{2'b11, 2'b00, 10'h010, 10'h020, 0,  0,    2'b00, 2'b00, 0,    1'b0, 1'b1, 10'h020, 0};
        tbl[8]  = '{2'b11, 2'b00, 10'h010, 10'h020, 0,  0,    2'b00, 2'b10, 0,    1'b0, 1'b0, 10'h020, 0};
        tbl[9]  = '{2'b01, 2'b00, 10'h010, 10'h000, 0,  0,    2'b01, 2'b00, 0,    1'b0, 1'b0, 10'h020, 0};
        tbl[10] = '{2'b00, 2'b00, 10'h000, 10'h000, 0,  0,    2'b00, 2'b00, 0,    1'b0, 1'b1, 10'h010, 0};
        tbl[11] = '{2'b00, 2'b00, 10'h000, 10'h000, 0,  0,    2'b00, 2'b01, 0,    1'b0, 1'b0, 10'h010, 0};
        tbl[12] = '{2'b10, 2'b10, 10'h000, 10'h3FF, 0,  ONES, 2'b10, 2'b00, 0,    1'b0, 1'b0, 10'h010, 0};
        tbl[13] = '{2'b00, 2'b00, 10'h000, 10'h000, 0,  0,    2'b00, 2'b00, 0,    1'b1, 1'b0, 10'h3FF, ONES};
        tbl[14] = '{2'b00, 2'b00, 10'h000, 10'h000, 0,  0,    2'b00, 2'b10, 0,    1'b0, 1'b0, 10'h3FF, 0};
        tbl[15] = '{2'b01, 2'b00, 10'h3FF, 10'h000, 0,  0,    2'b01, 2'b00, 0,    1'b0, 1'b0, 10'h3FF, 0};
        tbl[16] = '{2'b00, 2'b00, 10'h000, 10'h000, 0,  0,    2'b00, 2'b00, 0,    1'b0, 1'b1, 10'h3FF, 0};
        tbl[17] = '{2'b00, 2'b00, 10'h000, 10'h000, 0,  0,    2'b00, 2'b01, ONES, 1'b0, 1'b0, 10'h3FF, 0};

        do_reset();
        for (int k = 0; k < 18; k++) begin
            req_valid = tbl[k].v; req_we = tbl[k].we;
            req_addr0 = tbl[k].a0; req_addr1 = tbl[k].a1;
            req_wdata0 = tbl[k].d0; req_wdata1 = tbl[k].d1;
            #1;
            chk($sformatf("tbl%0d_ready", k), req_ready, tbl[k].e_rdy);
            chk($sformatf("tbl%0d_rsp_valid", k), rsp_valid, tbl[k].e_rsp);
            if (tbl[k].e_rsp != 2'b00) chk($sformatf("tbl%0d_rdata", k), rsp_rdata, tbl[k].e_rdata);
            chk($sformatf("tbl%0d_ram_we", k), ram_we, tbl[k].e_we);
            chk($sformatf("tbl%0d_ram_oe", k), ram_oe, tbl[k].e_oe);
            chk($sformatf("tbl%0d_ram_address", k), ram_address, tbl[k].e_addr);
            if (tbl[k].e_we) chk($sformatf("tbl%0d_ram_data_in", k), ram_data_in, tbl[k].e_din);
            tick();
        end

        // Both ports held valid from the first IDLE cycle after reset.
        do_reset();
        oe_cnt = 0;
        for (int c = 0; c < 14; c++) begin
            req_valid = (c < 12) ? 2'b11 : 2'b00; req_we = 2'b00;
            req_addr0 = 10'h010; req_addr1 = 10'h020;
            #1;
            if (req_valid[0] && req_ready[0]) begin hs_cyc.push_back(c); hs_port.push_back(1'b0); end
            if (req_valid[1] && req_ready[1]) begin hs_cyc.push_back(c); hs_port.push_back(1'b1); end
            if (ram_oe) oe_cnt++;
            tick();
        end
        chk("contend_hs_count", hs_cyc.size(), 4);
        for (int k = 0; k < 4 && k < hs_cyc.size(); k++) begin
            chk($sformatf("contend_hs%0d_cycle", k), hs_cyc[k], 3 * k);
            chk($sformatf("contend_hs%0d_port", k), hs_port[k], k % 2);
        end
        chk("contend_oe_cycles", oe_cnt, 4);
`ifdef RAM_ARB2_PERF_EN
        chk("perf_grant0", perf_grant0, 16'd2);
        chk("perf_grant1", perf_grant1, 16'd2);
        chk("perf_conflict", perf_conflict, 16'd4);
`else
        chk("perf_grant0_tied", perf_grant0, 16'd0);
        chk("perf_grant1_tied", perf_grant1, 16'd0);
        chk("perf_conflict_tied", perf_conflict, 16'd0);
`endif

        // Reset lands in the ACCESS cycle of a write; the write still commits.
        do_reset();
        req_valid = 2'b01; req_we = 2'b01; req_addr0 = 10'h007; req_wdata0 = CAFE;
        #1; chk("rstmid_ready", req_ready, 2'b01); tick();
        req_valid = 2'b00; reset = 1'b1;
        #1; chk("rstmid_ram_we", ram_we, 1'b1); chk("rstmid_addr", ram_address, 10'h007); tick();
        reset = 1'b0; req_valid = 2'b01; req_we = 2'b00;
        #1; chk("rstmid_no_rsp", rsp_valid, 2'b00); chk("rstmid_idle_ready", req_ready, 2'b01); tick();
        req_valid = 2'b00;
        #1; chk("rstmid_no_rsp2", rsp_valid, 2'b00); tick();
        #1; chk("rstmid_rsp_valid", rsp_valid, 2'b01); chk("rstmid_rdata", rsp_rdata, CAFE); tick();

        // Port 0 gives up while port 1 is being served.
        req_valid = 2'b10; req_we = 2'b00; req_addr1 = 10'h020;
        #1; chk("drop_p1_ready", req_ready, 2'b10); tick();
        op_cnt = 0; rsp0_cnt = 0; rsp1_cnt = 0;
        for (int c = 1; c < 7; c++) begin
            req_valid = (c < 2) ? 2'b01 : 2'b00; req_addr0 = 10'h005;
            #1;
            if (c == 1) chk("drop_p0_wait_ready", req_ready, 2'b00);
            if (ram_we || ram_oe) op_cnt++;
            if (rsp_valid[0]) rsp0_cnt++;
            if (rsp_valid[1]) rsp1_cnt++;
            tick();
        end
        chk("drop_ram_ops", op_cnt, 1);
        chk("drop_rsp0", rsp0_cnt, 0);
        chk("drop_rsp1", rsp1_cnt, 1);

        // Randomized traffic against an abstract serialised-memory model.
        do_reset();
        for (int i = 0; i < 8; i++) mmem[i] = '0;
        for (int i = 0; i < 2; i++) begin hold[i] = 1'b0; cv[i] = 1'b0; cwe[i] = 1'b0; ca[i] = '0; cd[i] = '0; end
        busy = 0; last = 1'b1;
        for (int cyc = 0; cyc < NRND + 4; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (cyc >= NRND) begin
                    cv[i] = 1'b0;
                end else if (!(hold[i] && $urandom_range(7) != 0)) begin
                    cv[i]  = 1'($urandom_range(1));
                    cwe[i] = 1'($urandom_range(1));
                    ca[i]  = 3'($urandom_range(7));
                    cd[i]  = {$urandom, $urandom};
                end
            end
            req_valid = {cv[1], cv[0]}; req_we = {cwe[1], cwe[0]};
            req_addr0 = {7'h20, ca[0]}; req_addr1 = {7'h20, ca[1]};
            req_wdata0 = cd[0]; req_wdata1 = cd[1];
            #1;
            exp_rdy = 2'b00; win = 1'b0;
            if (busy == 0 && (cv[0] || cv[1])) begin
                win = (cv[0] && cv[1]) ? ~last : cv[1];
                exp_rdy = win ? 2'b10 : 2'b01;
            end
            chk($sformatf("rnd%0d_ready", cyc), req_ready, exp_rdy);
            if (rq.size() > 0 && rq[0].due == cyc) begin
                r = rq.pop_front();
                chk($sformatf("rnd%0d_rsp_valid", cyc), rsp_valid, r.port ? 2'b10 : 2'b01);
                chk($sformatf("rnd%0d_rdata", cyc), rsp_rdata, r.data);
            end else begin
                chk($sformatf("rnd%0d_rsp_idle", cyc), rsp_valid, 2'b00);
            end
            if (exp_rdy != 2'b00) begin
                if (cwe[win]) begin mmem[ca[win]] = cd[win]; r.data = '0; end
                else r.data = mmem[ca[win]];
                r.due = cyc + 2; r.port = win; rq.push_back(r);
                last = win; busy = 2;
                hold[win] = 1'b0; hold[~win] = cv[~win];
            end else begin
                if (busy > 0) busy--;
                hold[0] = cv[0]; hold[1] = cv[1];
            end
            tick();
        end
        chk("rnd_drained", rq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arb2_ctrl.md
Name: ram_arb2_ctrl

Overview:
Two-requester arbiter and sequencer in front of the single-port synchronous RAM (64-bit data, 10-bit address, 1-cycle registered read).
- Port 0 is the instruction-fetch side; port 1 is the data/load-store side.
- Round-robin grant, one access in flight at a time.
- Drives the RAM's address, data_in, we and oe pins, and returns read data and write acks to the winning requester.

Parameters:
DATA_WIDTH, 64, RAM word width; must match the RAM.
ADDR_WIDTH, 10, RAM address width; must match the RAM.

Ports:
clk  in  1  single clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
req_valid  in  2  per-port request valid; bit i = port i
req_ready  out  2  per-port accept; a transfer occurs when valid and ready are both high
req_we  in  2  per-port op: 1 = write, 0 = read
req_addr0  in  ADDR_WIDTH  port 0 address
req_addr1  in  ADDR_WIDTH  port 1 address
req_wdata0  in  DATA_WIDTH  port 0 write data
req_wdata1  in  DATA_WIDTH  port 1 write data
rsp_valid  out  2  one-cycle response pulse to the granted port
rsp_rdata  out  DATA_WIDTH  read data, qualified by rsp_valid
ram_address  out  ADDR_WIDTH  to RAM address
ram_data_in  out  DATA_WIDTH  to RAM data_in
ram_we  out  1  to RAM we
ram_oe  out  1  to RAM oe
ram_data_out  in  DATA_WIDTH  from RAM data_out
perf_grant0  out  16  port 0 grant count (optional feature)
perf_grant1  out  16  port 1 grant count (optional feature)
perf_conflict  out  16  contention-cycle count (optional feature)

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Throughput is one operation per 3 cycles.
- IDLE:
  - req_ready[g] is high, combinationally, only for the arbiter pick g; the other bit is low.
  - On handshake, register addr, wdata, we and g; next state is ACCESS.
  - If no request is valid, stay in IDLE.
- Arbitration:
  - One valid requester: it wins.
  - Both valid: the port that is not last_grant wins.
  - last_grant updates on every handshake.
  - Reset value of last_grant is 1, so port 0 wins the first contention.
- ACCESS (cycle T+1 after handshake at T):
  - ram_address and ram_data_in come from the captured registers.
  - Write: ram_we=1, ram_oe=0. Read: ram_we=0, ram_oe=1.
  - RAM samples at the end of this cycle. Next state is RESP.
- RESP (T+2):
  - rsp_valid[g]=1 for exactly one cycle.
  - Read: rsp_rdata = ram_data_out (passthrough).
  - Write: rsp_rdata = 0.
  - ram_we=0, ram_oe=0. Next state is IDLE.
- Outside ACCESS, ram_we and ram_oe are 0. ram_address and ram_data_in hold their last values.
- Response path has no backpressure; requesters must accept rsp_valid.
- Requester rules: hold addr, we and wdata stable while valid is high and ready is low. Deasserting valid before ready is legal, and the pending request is dropped.
- Read-after-write to the same address from either port returns the new data; ops are fully serialised.
- Reset values: state=IDLE; req_ready=0 during reset; rsp_valid=0; ram_we=0; ram_oe=0; ram_address=0; ram_data_in=0; rsp_rdata=0; last_grant=1.
- Reset asserted mid-operation:
  - In ACCESS, the RAM op already on the pins commits at that edge.
  - No response is issued, and the FSM is in IDLE afterwards.
- Requests presented during ACCESS/RESP see req_ready=0 and wait.

Optional Feature:
Macro RAM_ARB2_PERF_EN.
- Defined:
  - perf_grant0 and perf_grant1 increment on each handshake of their port.
  - perf_conflict increments each cycle in IDLE with req_valid=2'b11.
  - All three counters saturate at 16'hFFFF and clear on reset.
- Undefined: the ports remain present, tied to 0, with no counter flops.

Decomposition:
- Package ram_arb2_pkg holds:
  - state enum typedef (IDLE, ACCESS, RESP)
  - port index constants PORT_IF=0 and PORT_LS=1
  - PERF_W=16
- Sub-module rr_arb2 is the combinational 2-way round-robin pick. It takes (req_valid[1:0], last_grant) and returns (pick, any_valid).

Test Plan:
- Port 0 write addr 0x005, data 0xDEAD_BEEF_0000_0001; then port 0 read 0x005 -> write ack rsp_valid[0] at T+2 with rdata 0; read returns 0xDEAD_BEEF_0000_0001 at T'+2.
- Both ports valid in the first IDLE cycle after reset, reads of 0x010 and 0x020 -> port 0 granted first, port 1 handshake 3 cycles later; ram_oe high exactly 1 cycle per op.
- Both held valid for 12 cycles -> grants alternate 0,1,0,1; with PERF_EN, perf_grant0=2 and perf_grant1=2; perf_conflict counts only contended IDLE cycles.
- Port 1 writes 0x3FF (max address) with 0xFFFF_FFFF_FFFF_FFFF, then port 0 reads 0x3FF -> read returns all-ones; ram_address=0x3FF during both ACCESS cycles.
- Reset asserted in the ACCESS cycle of a write to 0x007 -> no rsp_valid; FSM in IDLE; a later read of 0x007 returns the written data.
- Port 0 drops valid while waiting (port 1 busy) -> no grant is issued to port 0, and no RAM op occurs for that request.
